// File: rtl/mem_arbiter.sv
// Two-master (imem/dmem) arbiter onto one external line-memory port.
// Optional macro ARB_ROUND_ROBIN_EN: alternate tie winners instead of fixed imem priority.
`timescale 1ns/1ps
module mem_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic         imem_addr_valid,
  input  logic [31:0]  imem_addr,
  output logic         imem_data_ready,
  output logic [511:0] imem_data,
  input  logic         dmem_addr_valid,
  input  logic [31:0]  dmem_addr,
  input  logic         dmem_write_data_valid,
  input  logic [511:0] dmem_write_data,
  output logic         dmem_data_ready,
  output logic [511:0] dmem_data,
  output logic         ext_addr_valid,
  output logic [31:0]  ext_addr,
  output logic         ext_write_data_valid,
  output logic [511:0] ext_write_data,
  input  logic         ext_read_data_ready,
  input  logic [511:0] ext_read_data,
  output logic [1:0]   grant
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IMEM = 2'd1,
    ST_DMEM = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   w_tie_dmem;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_dmem;
  logic w_done;

  // Any exit from an owner state (completion or abort) counts as that owner finishing.
  assign w_done = (r_state != ST_IDLE) && (w_next_state == ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_dmem <= 1'b0;
    end else if (w_done) begin
      r_last_dmem <= (r_state == ST_DMEM);
    end
  end

  assign w_tie_dmem = ~r_last_dmem;
`else
  assign w_tie_dmem = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state         = r_state;
    grant                = 2'b00;
    ext_addr_valid       = 1'b0;
    ext_addr             = '0;
    ext_write_data_valid = 1'b0;
    ext_write_data       = '0;
    imem_data_ready      = 1'b0;
    dmem_data_ready      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (imem_addr_valid && dmem_addr_valid) begin
          w_next_state = w_tie_dmem ? ST_DMEM : ST_IMEM;
        end else if (imem_addr_valid) begin
          w_next_state = ST_IMEM;
        end else if (dmem_addr_valid) begin
          w_next_state = ST_DMEM;
        end
      end

      ST_IMEM: begin
        grant          = 2'b01;
        ext_addr_valid = imem_addr_valid;
        ext_addr       = imem_addr;
        // A dropped request aborts even if the external side answers in the same cycle.
        if (!imem_addr_valid) begin
          w_next_state = ST_IDLE;
        end else if (ext_read_data_ready) begin
          imem_data_ready = 1'b1;
          w_next_state    = ST_IDLE;
        end
      end

      ST_DMEM: begin
        grant                = 2'b10;
        ext_addr_valid       = dmem_addr_valid;
        ext_addr             = dmem_addr;
        ext_write_data_valid = dmem_write_data_valid;
        ext_write_data       = dmem_write_data;
        if (!dmem_addr_valid) begin
          w_next_state = ST_IDLE;
        end else if (ext_read_data_ready) begin
          dmem_data_ready = 1'b1;
          w_next_state    = ST_IDLE;
        end
      end

      default: w_next_state = ST_IDLE;
    endcase
  end

  assign imem_data = ext_read_data;
  assign dmem_data = ext_read_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table for single transactions,
// hand sequences for abort, stray ready, reset and contention; scoreboard for returned data.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         imem_addr_valid = 1'b0;
  logic [31:0]  imem_addr = '0;
  logic         imem_data_ready;
  logic [511:0] imem_data;
  logic         dmem_addr_valid = 1'b0;
  logic [31:0]  dmem_addr = '0;
  logic         dmem_write_data_valid = 1'b0;
  logic [511:0] dmem_write_data = '0;
  logic         dmem_data_ready;
  logic [511:0] dmem_data;
  logic         ext_addr_valid;
  logic [31:0]  ext_addr;
  logic         ext_write_data_valid;
  logic [511:0] ext_write_data;
  logic         ext_read_data_ready = 1'b0;
  logic [511:0] ext_read_data = '0;
  logic [1:0]   grant;

  mem_arbiter dut (
    .clk                   (clk),
    .rst                   (rst),
    .imem_addr_valid       (imem_addr_valid),
    .imem_addr             (imem_addr),
    .imem_data_ready       (imem_data_ready),
    .imem_data             (imem_data),
    .dmem_addr_valid       (dmem_addr_valid),
    .dmem_addr             (dmem_addr),
    .dmem_write_data_valid (dmem_write_data_valid),
    .dmem_write_data       (dmem_write_data),
    .dmem_data_ready       (dmem_data_ready),
    .dmem_data             (dmem_data),
    .ext_addr_valid        (ext_addr_valid),
    .ext_addr              (ext_addr),
    .ext_write_data_valid  (ext_write_data_valid),
    .ext_write_data        (ext_write_data),
    .ext_read_data_ready   (ext_read_data_ready),
    .ext_read_data         (ext_read_data),
    .grant                 (grant)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         is_dmem;
    logic [511:0] data;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic         iv;
    logic         dv;
    logic         dw;
    logic [31:0]  ia;
    logic [31:0]  da;
    logic [511:0] wd;
    int           lat;
    logic [1:0]   exp_grant;
    logic [31:0]  exp_addr;
    logic         exp_wv;
  } vec_t;
  vec_t vecs[5];

  // Reference last-owner: 0 = imem, 1 = dmem.
  logic m_last_dmem = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic tie_goes_dmem(input logic last_dmem);
`ifdef ARB_ROUND_ROBIN_EN
    return ~last_dmem;
`else
    return 1'b0 & last_dmem;
`endif
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic drop_requests();
    imem_addr_valid       = 1'b0;
    dmem_addr_valid       = 1'b0;
    dmem_write_data_valid = 1'b0;
  endtask

  // Called at negedge+2 while the owner holds the bus: return data, then check the IDLE gap.
  task automatic finish_txn(input logic is_dmem, input logic drop);
    logic [511:0] d;
    d = rand_line();
    ext_read_data       = d;
    ext_read_data_ready = 1'b1;
    sb_q.push_back('{is_dmem: is_dmem, data: d});
    @(negedge clk);
    ext_read_data_ready = 1'b0;
    if (drop) drop_requests();
    #2;
    check("sb_drained", 512'(sb_q.size()), 512'd0);
    check("idle_grant", 512'(grant), 512'd0);
    check("idle_ext_valid", 512'(ext_addr_valid), 512'd0);
    m_last_dmem = is_dmem;
  endtask

  // Scoreboard monitor: every data_ready pulse must match the oldest expected return.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (imem_data_ready || dmem_data_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_data_ready: imem %0b dmem %0b, expected none",
                   imem_data_ready, dmem_data_ready);
        end else begin
          e = sb_q.pop_front();
          check("rdy_imem", 512'(imem_data_ready), 512'(!e.is_dmem));
          check("rdy_dmem", 512'(dmem_data_ready), 512'(e.is_dmem));
          check("rd_data", e.is_dmem ? dmem_data : imem_data, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1);
  end

  initial begin
    logic       w_dmem;
    logic [1:0] exp_g;

    vecs[0] = '{iv: 1'b1, dv: 1'b0, dw: 1'b0, ia: 32'h0000_0040, da: 32'h0, wd: '0,
                lat: 3, exp_grant: 2'b01, exp_addr: 32'h0000_0040, exp_wv: 1'b0};
    vecs[1] = '{iv: 1'b0, dv: 1'b1, dw: 1'b1, ia: 32'h0, da: 32'h0000_8000, wd: {64{8'hA5}},
                lat: 2, exp_grant: 2'b10, exp_addr: 32'h0000_8000, exp_wv: 1'b1};
    vecs[2] = '{iv: 1'b0, dv: 1'b1, dw: 1'b0, ia: 32'h0, da: 32'h1234_5678, wd: {16{32'hDEAD_BEEF}},
                lat: 0, exp_grant: 2'b10, exp_addr: 32'h1234_5678, exp_wv: 1'b0};
    vecs[3] = '{iv: 1'b1, dv: 1'b0, dw: 1'b0, ia: 32'hFFFF_FFC0, da: 32'h0, wd: '0,
                lat: 1, exp_grant: 2'b01, exp_addr: 32'hFFFF_FFC0, exp_wv: 1'b0};
    vecs[4] = '{iv: 1'b0, dv: 1'b1, dw: 1'b1, ia: 32'h0, da: 32'h0000_0000, wd: {32{16'h5A3C}},
                lat: 5, exp_grant: 2'b10, exp_addr: 32'h0000_0000, exp_wv: 1'b1};

    // Reset state: outputs stay quiet even with requests and ready applied.
    imem_addr_valid     = 1'b1;
    imem_addr           = 32'h40;
    ext_read_data_ready = 1'b1;
    #12;
    check("rst_grant", 512'(grant), 512'd0);
    check("rst_ext_valid", 512'(ext_addr_valid), 512'd0);
    check("rst_ext_wv", 512'(ext_write_data_valid), 512'd0);
    check("rst_imem_rdy", 512'(imem_data_ready), 512'd0);
    drop_requests();
    ext_read_data_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Table-driven single transactions.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      imem_addr_valid       = vecs[i].iv;
      imem_addr             = vecs[i].ia;
      dmem_addr_valid       = vecs[i].dv;
      dmem_addr             = vecs[i].da;
      dmem_write_data_valid = vecs[i].dw;
      dmem_write_data       = vecs[i].wd;
      @(negedge clk);
      #2;
      check("vec_grant", 512'(grant), 512'(vecs[i].exp_grant));
      check("vec_ext_valid", 512'(ext_addr_valid), 512'd1);
      check("vec_ext_addr", 512'(ext_addr), 512'(vecs[i].exp_addr));
      check("vec_ext_wv", 512'(ext_write_data_valid), 512'(vecs[i].exp_wv));
      if (vecs[i].dv) check("vec_ext_wd", ext_write_data, vecs[i].wd);
      for (int c = 0; c < vecs[i].lat; c++) begin
        @(negedge clk);
        #2;
        check("vec_hold_grant", 512'(grant), 512'(vecs[i].exp_grant));
        check("vec_hold_wv", 512'(ext_write_data_valid), 512'(vecs[i].exp_wv));
      end
      finish_txn(vecs[i].dv, 1'b1);
    end

    // Abort: dmem drops its request after two cycles with no external response.
    @(negedge clk);
    dmem_addr_valid = 1'b1;
    dmem_addr       = 32'h0000_9000;
    @(negedge clk);
    #2;
    check("abort_grant", 512'(grant), 512'b10);
    repeat (2) @(negedge clk);
    dmem_addr_valid = 1'b0;
    #2;
    check("abort_ext_valid_drop", 512'(ext_addr_valid), 512'd0);
    @(negedge clk);
    #2;
    check("abort_idle_grant", 512'(grant), 512'd0);
    check("abort_idle_ext_valid", 512'(ext_addr_valid), 512'd0);
    m_last_dmem = 1'b1;

    // Stray external ready while idle.
    @(negedge clk);
    ext_read_data       = rand_line();
    ext_read_data_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #2;
      check("stray_grant", 512'(grant), 512'd0);
      check("stray_rdy", 512'({imem_data_ready, dmem_data_ready}), 512'd0);
    end
    ext_read_data_ready = 1'b0;

    // Asynchronous reset in the middle of an imem transaction.
    @(negedge clk);
    imem_addr_valid = 1'b1;
    imem_addr       = 32'h0000_0C40;
    @(negedge clk);
    #2;
    check("rmid_grant", 512'(grant), 512'b01);
    #1;
    rst = 1'b0;
    #1;
    check("rmid_async_grant", 512'(grant), 512'd0);
    check("rmid_async_ext_valid", 512'(ext_addr_valid), 512'd0);
    m_last_dmem = 1'b0;
    @(negedge clk);
    #2;
    check("rmid_held_grant", 512'(grant), 512'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    check("rmid_regrant", 512'(grant), 512'b01);
    check("rmid_regrant_addr", 512'(ext_addr), 512'h0C40);
    finish_txn(1'b0, 1'b1);

    // Fresh reset, then four back-to-back ties with both requests held throughout.
    @(negedge clk);
    rst = 1'b0;
    m_last_dmem = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    imem_addr             = 32'h0000_0100;
    dmem_addr             = 32'h0000_0200;
    dmem_write_data       = '0;
    dmem_write_data_valid = 1'b0;
    imem_addr_valid       = 1'b1;
    dmem_addr_valid       = 1'b1;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      #2;
      w_dmem = tie_goes_dmem(m_last_dmem);
      exp_g  = w_dmem ? 2'b10 : 2'b01;
      check("tie_grant", 512'(grant), 512'(exp_g));
      check("tie_ext_addr", 512'(ext_addr), w_dmem ? 512'h200 : 512'h100);
      finish_txn(w_dmem, r == 3);
    end

    @(negedge clk);
    check("sb_final_empty", 512'(sb_q.size()), 512'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; rst input 1, asynchronous active-low reset.
REQ-002 SHALL have instruction-cache request ports: imem_addr_valid input 1, request; imem_addr input 32, line address.
REQ-003 SHALL have instruction-cache response ports: imem_data_ready output 1, line returned; imem_data output 512, read line.
REQ-004 SHALL have data-cache request ports: dmem_addr_valid input 1, request; dmem_addr input 32, line address; dmem_write_data_valid input 1, request is a write; dmem_write_data input 512, write line.
REQ-005 SHALL have data-cache response ports: dmem_data_ready output 1, access complete; dmem_data output 512, read line.
REQ-006 SHALL have external request ports: ext_addr_valid output 1; ext_addr output 32; ext_write_data_valid output 1; ext_write_data output 512.
REQ-007 SHALL have external response ports: ext_read_data_ready input 1, completes reads and writes; ext_read_data input 512.
REQ-008 SHALL have a status port: grant output 2, one-hot owner, bit0 imem, bit1 dmem.

Function
REQ-009 SHALL implement FSM states IDLE, IMEM, DMEM.
REQ-010 IDLE, no valid request: SHALL remain in IDLE.
REQ-011 IDLE, exactly one valid request: SHALL enter that requester's state at the next edge.
REQ-012 IDLE, both requests valid: SHALL select the winner per REQ-026/027.
REQ-013 IMEM/DMEM: SHALL drive ext_addr, ext_write_data_valid and ext_write_data combinationally from the owner.
REQ-014 IMEM/DMEM: SHALL hold ext_addr_valid=1 while the owner's addr_valid=1.
REQ-015 imem is read-only: in IMEM, ext_write_data_valid SHALL be 0.
REQ-016 IDLE: all ext_* outputs SHALL be 0.
REQ-017 Latency: request sampled in IDLE -> ext_addr_valid=1 exactly one cycle later.
REQ-018 Owner state with ext_read_data_ready=1: SHALL assert the owner's data_ready that same cycle (combinational) and return to IDLE.
REQ-019 The non-owner's data_ready SHALL be 0 at all times.
REQ-020 After every completion SHALL spend >=1 cycle in IDLE, so the completed cache can drop valid before re-arbitration.
REQ-021 imem_data and dmem_data SHALL both equal ext_read_data (passthrough); qualification is by data_ready only.
REQ-022 Owner deasserts addr_valid before ext_read_data_ready: SHALL abort, return to IDLE, emit no data_ready, and record the abort as a completion for REQ-026.
REQ-023 ext_read_data_ready=1 in IDLE: SHALL be ignored.
REQ-024 grant SHALL be 2'b01 in IMEM, 2'b10 in DMEM, 2'b00 in IDLE.

Reset
REQ-025 rst=0 SHALL asynchronously force IDLE, grant=0, last-owner register=imem, and all ext_* and *_data_ready outputs to 0; a transaction in flight is dropped with no data_ready; operation resumes at the first clk edge after rst deasserts.

Configuration
REQ-026 With ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant SHALL go to the master that did not complete last (register updated on each completion or abort; reset value imem, so dmem wins first tie).
REQ-027 Without ARB_ROUND_ROBIN_EN: imem SHALL always win ties (fixed priority) and the last-owner register SHALL be absent.

Verification
REQ-028 Single read: imem_addr_valid=1, imem_addr=0x40, ext ready 3 cycles after ext_addr_valid -> ext_addr=0x40 one cycle after request; imem_data_ready=1 for one cycle with imem_data=ext_read_data; ext_write_data_valid=0 throughout.
REQ-029 Write: dmem_addr_valid=1, dmem_write_data_valid=1, dmem_addr=0x8000, data=512'hA5... -> ext_write_data_valid=1, ext_write_data=0xA5...; dmem_data_ready=1 on ready; imem_data_ready=0.
REQ-030 Contention, 4 back-to-back simultaneous requests: with ARB_ROUND_ROBIN_EN, grant order dmem,imem,dmem,imem; without it, imem is granted every time.
REQ-031 Abort: grant dmem, drop dmem_addr_valid after 2 cycles with no ext ready -> IDLE next edge, ext_addr_valid=0, no dmem_data_ready.
REQ-032 Reset mid-transaction: rst=0 during IMEM -> grant=0 and ext_addr_valid=0 immediately (asynchronously); after release with imem still valid, new grant one edge later.
REQ-033 Stray ready: ext_read_data_ready=1 in IDLE -> both data_ready outputs stay 0, state stays IDLE.
